// File: rtl/cache_lookup_plru_if.sv
// Lookup request, fill notification and registered response bundle for cache_lookup_plru.
// Latency: none (wires only); the response fields are valid one cycle after the request.
// Backpressure: none; the slave accepts one lookup and one fill every cycle.
// Ports: master = cache controller / tag array side (drives lk_*, way_*, fill_*),
//        slave  = cache_lookup_plru (drives rsp_*, err_multi_hit, hit_cnt, miss_cnt).
interface cache_lookup_plru_if #(
    parameter int WAYS     = 8,
    parameter int WAYS_REP = 3,
    parameter int TAG      = 12,
    parameter int INDEX    = 3,
    parameter int CNT_W    = 16
);
    logic                  lk_valid;
    logic                  lk_op;
    logic [INDEX-1:0]      lk_index;
    logic [TAG-1:0]        lk_tag;
    logic [WAYS*TAG-1:0]   way_tags;
    logic [2*WAYS-1:0]     way_state;
    logic                  fill_valid;
    logic [INDEX-1:0]      fill_index;
    logic [WAYS_REP-1:0]   fill_way;
    logic                  rsp_valid;
    logic                  rsp_hit;
    logic [WAYS_REP-1:0]   rsp_way;
    logic [1:0]            rsp_state;
    logic [WAYS_REP-1:0]   rsp_victim;
    logic                  rsp_upgrade;
    logic                  rsp_multi_hit;
    logic                  err_multi_hit;
    logic [CNT_W-1:0]      hit_cnt;
    logic [CNT_W-1:0]      miss_cnt;

    modport master (
        output lk_valid, lk_op, lk_index, lk_tag, way_tags, way_state,
               fill_valid, fill_index, fill_way,
        input  rsp_valid, rsp_hit, rsp_way, rsp_state, rsp_victim, rsp_upgrade,
               rsp_multi_hit, err_multi_hit, hit_cnt, miss_cnt
    );

    modport slave (
        input  lk_valid, lk_op, lk_index, lk_tag, way_tags, way_state,
               fill_valid, fill_index, fill_way,
        output rsp_valid, rsp_hit, rsp_way, rsp_state, rsp_victim, rsp_upgrade,
               rsp_multi_hit, err_multi_hit, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_lookup_plru.sv
// N-way MESI-qualified tag lookup with per-set tree PLRU victim choice and hit/miss statistics.
// Latency: one cycle, lookup at edge N is reported at edge N+1; PLRU updates visible next cycle.
// Backpressure: none; one lookup and one fill accepted every cycle.
// Ports: clk, rstb (synchronous, active-high) plus cl (slave modport of cache_lookup_plru_if):
//        lk_* request and way_* array data in, fill_* PLRU touch in, rsp_* / err / counters out.
module cache_lookup_plru #(
    parameter int WAYS     = 8,
    parameter int WAYS_REP = 3,
    parameter int TAG      = 12,
    parameter int INDEX    = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rstb,
    cache_lookup_plru_if.slave  cl
);
    localparam int SETS = 2**INDEX;

    typedef logic [WAYS-2:0]     tree_t;
    typedef logic [WAYS_REP-1:0] way_t;

    tree_t plru [SETS];

    // Point every node on the path to 'way' away from it. Node indices are kept
    // in WAYS_REP bits; the child computed after the last level is never used.
    function automatic tree_t touch(input tree_t t, input way_t way);
        tree_t r;
        way_t  node;
        way_t  w;
        logic  b;
        r    = t;
        node = '0;
        w    = way;
        for (int lvl = 0; lvl < WAYS_REP; lvl++) begin
            b       = w[WAYS_REP-1];
            r[node] = ~b;
            node    = (node << 1) + way_t'(1) + way_t'(b);
            w       = w << 1;
        end
        return r;
    endfunction

    // Walk from the root: each bit picks the half holding the victim.
    function automatic way_t walk(input tree_t t);
        way_t node;
        way_t v;
        node = '0;
        v    = '0;
        for (int lvl = 0; lvl < WAYS_REP; lvl++) begin
            v    = (v << 1) | way_t'(t[node]);
            node = (node << 1) + way_t'(1) + way_t'(t[node]);
        end
        return v;
    endfunction

    logic [WAYS-1:0] match;
    logic [WAYS-1:0] invalid;
    logic            any_hit;
    logic            any_inv;
    logic            multi;
    logic            lk_hit;
    way_t            hit_way;
    way_t            inv_way;
    way_t            victim;
    logic [1:0]      hit_state;
    tree_t           cur_tree;
    tree_t           hit_tree;
    tree_t           fill_base;
    tree_t           fill_tree;

    always_comb begin
        match     = '0;
        invalid   = '0;
        hit_way   = '0;
        hit_state = '0;
        inv_way   = '0;
        // Descending scan so the lowest matching / invalid way is the one kept.
        for (int w = WAYS-1; w >= 0; w--) begin
            invalid[w] = (cl.way_state[2*w +: 2] == 2'b00);
            match[w]   = (cl.way_state[2*w +: 2] != 2'b00) &&
                         (cl.way_tags[w*TAG +: TAG] == cl.lk_tag);
            if (match[w]) begin
                hit_way   = way_t'(w);
                hit_state = cl.way_state[2*w +: 2];
            end
            if (invalid[w]) begin
                inv_way = way_t'(w);
            end
        end
        any_hit  = |match;
        any_inv  = |invalid;
        // More than one bit set: clearing the lowest set bit leaves something.
        multi    = |(match & (match - WAYS'(1)));
        lk_hit   = cl.lk_valid && any_hit;
        cur_tree = plru[cl.lk_index];
        victim   = any_inv ? inv_way : walk(cur_tree);
        hit_tree = touch(cur_tree, hit_way);
        // Same-set hit and fill: the fill is layered on top of the hit update.
        fill_base = (lk_hit && (cl.fill_index == cl.lk_index)) ? hit_tree
                                                               : plru[cl.fill_index];
        fill_tree = touch(fill_base, cl.fill_way);
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            for (int s = 0; s < SETS; s++) begin
                plru[s] <= '0;
            end
            cl.rsp_valid     <= 1'b0;
            cl.rsp_hit       <= 1'b0;
            cl.rsp_way       <= '0;
            cl.rsp_state     <= '0;
            cl.rsp_victim    <= '0;
            cl.rsp_upgrade   <= 1'b0;
            cl.rsp_multi_hit <= 1'b0;
            cl.err_multi_hit <= 1'b0;
            cl.hit_cnt       <= '0;
            cl.miss_cnt      <= '0;
        end else begin
            if (lk_hit) begin
                plru[cl.lk_index] <= hit_tree;
            end
            if (cl.fill_valid) begin
                plru[cl.fill_index] <= fill_tree;
            end
            cl.rsp_valid     <= cl.lk_valid;
            cl.rsp_hit       <= lk_hit;
            cl.rsp_way       <= lk_hit ? hit_way : '0;
            cl.rsp_state     <= lk_hit ? hit_state : 2'b00;
            cl.rsp_victim    <= (cl.lk_valid && !any_hit) ? victim : '0;
            cl.rsp_upgrade   <= lk_hit && cl.lk_op && (hit_state == 2'b01);
            cl.rsp_multi_hit <= cl.lk_valid && multi;
            if (cl.lk_valid && multi) begin
                cl.err_multi_hit <= 1'b1;
            end
            if (lk_hit && (cl.hit_cnt != '1)) begin
                cl.hit_cnt <= cl.hit_cnt + CNT_W'(1);
            end
            if (cl.lk_valid && !any_hit && (cl.miss_cnt != '1)) begin
                cl.miss_cnt <= cl.miss_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_cache_lookup_plru.sv
// Directed self-checking bench for cache_lookup_plru (CNT_W = 4 to reach saturation quickly).
// Latency: checks sample outputs 1 time unit after the edge that registers each lookup.
// Backpressure: none exercised; the DUT accepts every cycle.
module tb_cache_lookup_plru;
    localparam int WAYS     = 8;
    localparam int WAYS_REP = 3;
    localparam int TAG      = 12;
    localparam int INDEX    = 3;
    localparam int CNT_W    = 4;
    localparam logic [TAG-1:0] REQ = 12'h5A3;

    logic clk = 1'b0;
    logic rstb;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    cache_lookup_plru_if #(.WAYS(WAYS), .WAYS_REP(WAYS_REP), .TAG(TAG),
                           .INDEX(INDEX), .CNT_W(CNT_W)) bus ();

    cache_lookup_plru #(.WAYS(WAYS), .WAYS_REP(WAYS_REP), .TAG(TAG),
                        .INDEX(INDEX), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rstb (rstb),
        .cl   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every way valid in state st, tags 0x100+w (never equal to REQ).
    task automatic load_set(input logic [1:0] st);
        for (int w = 0; w < WAYS; w++) begin
            bus.way_tags[w*TAG +: TAG] = TAG'(12'h100 + w);
            bus.way_state[2*w +: 2]    = st;
        end
    endtask

    task automatic cyc(input bit lv, input bit op, input logic [INDEX-1:0] idx,
                       input bit fv, input logic [INDEX-1:0] fidx,
                       input logic [WAYS_REP-1:0] fw);
        bus.lk_valid   = lv;
        bus.lk_op      = op;
        bus.lk_index   = idx;
        bus.lk_tag     = REQ;
        bus.fill_valid = fv;
        bus.fill_index = fidx;
        bus.fill_way   = fw;
        @(posedge clk);
        #1;
        bus.lk_valid   = 1'b0;
        bus.fill_valid = 1'b0;
    endtask

    initial begin
        rstb           = 1'b1;
        bus.lk_valid   = 1'b0;
        bus.lk_op      = 1'b0;
        bus.lk_index   = '0;
        bus.lk_tag     = '0;
        bus.fill_valid = 1'b0;
        bus.fill_index = '0;
        bus.fill_way   = '0;
        load_set(2'b01);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.rsp_valid), 0);
        check("rst_hit_cnt", 32'(bus.hit_cnt), 0);
        check("rst_miss_cnt", 32'(bus.miss_cnt), 0);
        check("rst_err", 32'(bus.err_multi_hit), 0);
        rstb = 1'b0;

        // Hit in way 5, state E, set 2.
        load_set(2'b01);
        bus.way_tags[5*TAG +: TAG] = REQ;
        bus.way_state[10 +: 2]     = 2'b10;
        cyc(1, 0, 3'd2, 0, 3'd0, 3'd0);
        check("hit_valid", 32'(bus.rsp_valid), 1);
        check("hit_hit", 32'(bus.rsp_hit), 1);
        check("hit_way", 32'(bus.rsp_way), 5);
        check("hit_state", 32'(bus.rsp_state), 2);
        check("hit_victim", 32'(bus.rsp_victim), 0);
        check("hit_multi", 32'(bus.rsp_multi_hit), 0);
        check("hit_cnt1", 32'(bus.hit_cnt), 1);

        // PLRU walk on set 0: reset tree -> 0, after fill 0 -> 4, after fill 4 -> 2.
        load_set(2'b01);
        cyc(1, 0, 3'd0, 0, 3'd0, 3'd0);
        check("miss_hit", 32'(bus.rsp_hit), 0);
        check("miss_victim0", 32'(bus.rsp_victim), 0);
        check("miss_cnt1", 32'(bus.miss_cnt), 1);
        cyc(0, 0, 3'd0, 1, 3'd0, 3'd0);
        check("idle_valid", 32'(bus.rsp_valid), 0);
        check("idle_victim", 32'(bus.rsp_victim), 0);
        cyc(1, 0, 3'd0, 0, 3'd0, 3'd0);
        check("miss_victim4", 32'(bus.rsp_victim), 4);
        cyc(0, 0, 3'd0, 1, 3'd0, 3'd4);
        cyc(1, 0, 3'd0, 0, 3'd0, 3'd0);
        check("miss_victim2", 32'(bus.rsp_victim), 2);
        check("miss_cnt3", 32'(bus.miss_cnt), 3);

        // Invalid way overrides the tree.
        bus.way_state[12 +: 2] = 2'b00;
        cyc(1, 0, 3'd0, 0, 3'd0, 3'd0);
        check("inv_victim6", 32'(bus.rsp_victim), 6);

        // Tag match on an invalid way is a miss.
        load_set(2'b01);
        bus.way_tags[3*TAG +: TAG] = REQ;
        bus.way_state[6 +: 2]      = 2'b00;
        cyc(1, 0, 3'd0, 0, 3'd0, 3'd0);
        check("inv_match_hit", 32'(bus.rsp_hit), 0);
        check("inv_match_victim", 32'(bus.rsp_victim), 3);
        check("miss_cnt5", 32'(bus.miss_cnt), 5);

        // Same-cycle hit (way 0) and fill (way 7) on set 3: fill wins shared nodes -> victim 2.
        load_set(2'b01);
        bus.way_tags[0 +: TAG] = REQ;
        cyc(1, 0, 3'd3, 1, 3'd3, 3'd7);
        check("hf_hit", 32'(bus.rsp_hit), 1);
        check("hf_way", 32'(bus.rsp_way), 0);
        load_set(2'b01);
        cyc(1, 0, 3'd3, 0, 3'd0, 3'd0);
        check("hf_victim", 32'(bus.rsp_victim), 2);

        // Upgrade cases on way 1, set 1.
        load_set(2'b01);
        bus.way_tags[1*TAG +: TAG] = REQ;
        cyc(1, 1, 3'd1, 0, 3'd0, 3'd0);
        check("upg_s_wr", 32'(bus.rsp_upgrade), 1);
        check("upg_s_state", 32'(bus.rsp_state), 1);
        cyc(1, 0, 3'd1, 0, 3'd0, 3'd0);
        check("upg_s_rd", 32'(bus.rsp_upgrade), 0);
        bus.way_state[2 +: 2] = 2'b11;
        cyc(1, 1, 3'd1, 0, 3'd0, 3'd0);
        check("upg_m_wr", 32'(bus.rsp_upgrade), 0);
        check("upg_m_state", 32'(bus.rsp_state), 3);
        check("hit_cnt5", 32'(bus.hit_cnt), 5);

        // Multi-hit on ways 2 and 7, then clean misses keep the sticky error.
        load_set(2'b10);
        bus.way_tags[2*TAG +: TAG] = REQ;
        bus.way_tags[7*TAG +: TAG] = REQ;
        cyc(1, 0, 3'd4, 0, 3'd0, 3'd0);
        check("mh_hit", 32'(bus.rsp_hit), 1);
        check("mh_way", 32'(bus.rsp_way), 2);
        check("mh_multi", 32'(bus.rsp_multi_hit), 1);
        check("mh_err", 32'(bus.err_multi_hit), 1);
        load_set(2'b01);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 3'd4, 0, 3'd0, 3'd0);
            check("mh_clean_multi", 32'(bus.rsp_multi_hit), 0);
            check("mh_err_sticky", 32'(bus.err_multi_hit), 1);
        end

        // Reset together with a lookup drops the response and clears everything.
        rstb = 1'b1;
        cyc(1, 0, 3'd4, 0, 3'd0, 3'd0);
        check("rl_valid", 32'(bus.rsp_valid), 0);
        check("rl_hit_cnt", 32'(bus.hit_cnt), 0);
        check("rl_miss_cnt", 32'(bus.miss_cnt), 0);
        check("rl_err", 32'(bus.err_multi_hit), 0);
        rstb = 1'b0;

        // Saturation: 20 hits on a 4-bit counter stop at 15.
        load_set(2'b10);
        bus.way_tags[0 +: TAG] = REQ;
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 3'd5, 0, 3'd0, 3'd0);
            if (i == 0) check("sat_first", 32'(bus.hit_cnt), 1);
        end
        check("sat_hit_cnt", 32'(bus.hit_cnt), 15);
        check("sat_miss_cnt", 32'(bus.miss_cnt), 0);

        rstb = 1'b1;
        cyc(1, 0, 3'd5, 0, 3'd0, 3'd0);
        check("rl2_valid", 32'(bus.rsp_valid), 0);
        check("rl2_hit_cnt", 32'(bus.hit_cnt), 0);
        rstb = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_lookup_plru.md
Name: cache_lookup_plru

Overview:
- Parametrised, registered N-way tag lookup for the set-associative cache.
- Compares a request tag against all ways of the addressed set, qualifying each way by its MESI state.
- Returns hit, way, line state and a replacement victim one cycle later.
- Owns the per-set tree pseudo-LRU state and the hit/miss statistics counters.
- Sits between the tag/state array read port and the cache controller FSM.

Parameters:
- WAYS, 8, associativity; power of two, at least 2.
- WAYS_REP, 3, way index width; equals log2(WAYS).
- TAG, 12, tag width in bits.
- INDEX, 3, set index width; SETS = 2**INDEX.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  sole clock.
- rstb  in  1  reset; synchronous, active-high.
- lk_valid  in  1  lookup request this cycle.
- lk_op  in  1  0 = read, 1 = write.
- lk_index  in  INDEX  set index of the lookup.
- lk_tag  in  TAG  request tag.
- way_tags  in  WAYS*TAG  tags of the addressed set; way w occupies bits [w*TAG +: TAG].
- way_state  in  2*WAYS  MESI state per way at [2w +: 2]; encoding 00 = I, 01 = S, 10 = E, 11 = M.
- fill_valid  in  1  a line fill or allocation completed.
- fill_index  in  INDEX  set index of the fill.
- fill_way  in  WAYS_REP  way that was filled.
- rsp_valid  out  1  response valid.
- rsp_hit  out  1  tag hit.
- rsp_way  out  WAYS_REP  hit way; 0 on a miss.
- rsp_state  out  2  MESI state of the hit way; 00 on a miss.
- rsp_victim  out  WAYS_REP  replacement way on a miss; 0 on a hit.
- rsp_upgrade  out  1  write hit to a line in S state; the controller must issue a bus upgrade.
- rsp_multi_hit  out  1  more than one valid way matched.
- err_multi_hit  out  1  sticky multi-hit error.
- hit_cnt  out  CNT_W  number of lookup hits.
- miss_cnt  out  CNT_W  number of lookup misses.

Behaviour:
- Reset (rstb = 1 at a rising edge):
  - all outputs go to 0, including both counters and err_multi_hit;
  - all PLRU bits of every set clear to 0.
  - Reset has priority over a lookup or fill in the same cycle; any in-flight response is dropped.
- Latency: one cycle. A lookup accepted at edge N is reported at edge N+1. No backpressure; one lookup per cycle is accepted.
- rsp_valid is a registered copy of lk_valid.
- When rsp_valid = 0, all rsp_* outputs are 0.
- Hit qualification: a way hits when its tag equals lk_tag AND its state is not I. A way in state I never hits, even when its tag matches.
- Multiple matches:
  - rsp_hit = 1 and rsp_way = lowest matching index;
  - rsp_multi_hit = 1;
  - err_multi_hit sets and stays set until reset.
- rsp_upgrade = 1 only for lk_op = 1 with a hit on state S.
- Victim selection on a miss:
  - if any way is in state I, the lowest-index invalid way;
  - otherwise, the way selected by the PLRU tree of lk_index.
- PLRU tree organisation:
  - WAYS-1 bits per set, heap ordered: node 0 is the root; children of node n are 2n+1 and 2n+2.
  - Bit = 0 means the victim is in the lower half; bit = 1 means the upper half.
  - The victim is found by walking from the root.
- PLRU update: an access to way w sets every node on w's path to point away from w.
  - A lookup hit updates the tree for (lk_index, rsp_way).
  - A fill updates the tree for (fill_index, fill_way).
  - A miss does not update the tree.
- Hit update and fill to the same index in the same cycle: the hit update is applied first, then the fill; on shared nodes the fill value wins.
- Visibility: a tree update at edge N is visible to a lookup presented in cycle N+1 (back-to-back accesses to the same set). No bypass is needed.
- Counters:
  - hit_cnt increments on each valid hit; miss_cnt increments on each valid miss.
  - Both saturate at 2**CNT_W-1 and never wrap.
  - A multi-hit counts as one hit.

Test Plan:
- Reset, then a lookup on index 2 with tag 0x5A3 present in way 5 with state E. Required at the next edge: rsp_valid = 1, rsp_hit = 1, rsp_way = 5, rsp_state = 10, rsp_victim = 0, hit_cnt = 1.
- All ways valid, tags mismatch, PLRU reset. Required: miss, rsp_victim = 0, miss_cnt = 1.
  - Then fill way 0, then miss again. Required: rsp_victim = 4.
  - Then fill way 4, then miss again. Required: rsp_victim = 2.
- Miss with way 6 in state I and all other ways valid. Required: rsp_victim = 6 regardless of the PLRU bits.
  - Way 3 in state I with a tag match. Required: a miss.
- Write lookup hitting way 1 in state S. Required: rsp_upgrade = 1.
  - The same lookup with lk_op = 0. Required: rsp_upgrade = 0.
  - Way 1 in state M with lk_op = 1. Required: rsp_upgrade = 0.
- Tag matches in ways 2 and 7, both valid. Required: rsp_way = 2, rsp_multi_hit = 1, and err_multi_hit stays 1 through 10 further clean lookups until rstb is asserted.
- Counter saturation with CNT_W = 4: 20 hits give hit_cnt = 15.
  - rstb asserted in the same cycle as a lookup: the next cycle has rsp_valid = 0 and the counters at 0.
